input_bram_loader: RTL and testbench

- Upstream stage of the input transfer controller.
- Accepts a valid/ready stream of 32-bit input-feature words and writes them sequentially into the input BRAM through its write port (waddress/wenable/data).
- After each band of KERNEL_ROW_SIZE rows (channel × col × KERNEL_ROW_SIZE words) is stored, pulses the controller's start-transfer input. It then waits for a band-release before overwriting the buffer.

---
 rtl/input_bram_loader.sv | 190 +++++++++++++++++++
 tb/tb_input_bram_loader.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_bram_loader.sv
// Stream-to-BRAM band loader: writes channel*col*KERNEL_ROW_SIZE words per band into the
// input BRAM, then hands the band to the transfer controller and waits for its release.
module input_bram_loader #(
   parameter int INPUT_BRAM_DEPTH         = 224*244,
   parameter int INPUT_BRAM_ADDRESS_WIDTH = $clog2(INPUT_BRAM_DEPTH),
   parameter int KERNEL_ROW_SIZE          = 3,
   parameter int DATA_WIDTH               = 32,
   parameter int INPUT_CHANNEL_WIDTH      = 8,
   parameter int INPUT_COL_WIDTH          = 6,
   parameter int BAND_COUNT_WIDTH         = 6
) (
   input  logic                                i_clock,
   input  logic                                i_reset,
   input  logic                                i_enable,
   input  logic                                i_start,
   input  logic [INPUT_CHANNEL_WIDTH-1:0]      i_feature_channel,
   input  logic [INPUT_COL_WIDTH-1:0]          i_feature_col,
   input  logic [BAND_COUNT_WIDTH-1:0]         i_band_total,
   input  logic                                i_s_valid,
   output logic                                o_s_ready,
   input  logic [DATA_WIDTH-1:0]               i_s_data,
   input  logic                                i_reset_busy,
   input  logic                                i_band_release,
   output logic                                o_wenable,
   output logic [INPUT_BRAM_ADDRESS_WIDTH-1:0] o_waddress,
   output logic [DATA_WIDTH-1:0]               o_bram_data,
   output logic                                o_start_transfer_process,
   output logic [BAND_COUNT_WIDTH-1:0]         o_band_index,
   output logic                                o_frame_done,
   output logic                                o_cfg_error,
   output logic                                o_busy
);

   localparam int AW         = INPUT_BRAM_ADDRESS_WIDTH;
   localparam int BW_W       = AW + 2;
   localparam int KR_W       = $clog2(KERNEL_ROW_SIZE + 1);
   localparam int PROD_W_RAW = INPUT_CHANNEL_WIDTH + INPUT_COL_WIDTH + KR_W;
   localparam int PROD_W     = (PROD_W_RAW > BW_W) ? PROD_W_RAW : BW_W;

   localparam logic [PROD_W-1:0] DEPTH_P = PROD_W'(INPUT_BRAM_DEPTH);
   localparam logic [PROD_W-1:0] KROW_P  = PROD_W'(KERNEL_ROW_SIZE);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_WAIT_RST = 3'd1;
   localparam logic [2:0] S_LOAD     = 3'd2;
   localparam logic [2:0] S_START    = 3'd3;
   localparam logic [2:0] S_HOLD     = 3'd4;

   logic [2:0]                  state_q,      state_d;
   logic [AW-1:0]               addr_q,       addr_d;
   logic [BW_W-1:0]             band_words_q, band_words_d;
   logic [BAND_COUNT_WIDTH-1:0] band_total_q, band_total_d;
   logic [BAND_COUNT_WIDTH-1:0] band_idx_q,   band_idx_d;
   logic                        cfg_error_q,  cfg_error_d;
   logic                        wenable_q,    wenable_d;
   logic [AW-1:0]               waddress_q,   waddress_d;
   logic [DATA_WIDTH-1:0]       bram_data_q,  bram_data_d;
   logic                        start_q,      start_d;
   logic                        frame_done_q, frame_done_d;
   logic                        busy_q,       busy_d;

   logic [PROD_W-1:0] cfg_words;
   logic              cfg_bad;
   logic              accept;
   logic              last_word;
   logic              last_band;

   // Product is formed wide enough that an oversized configuration cannot wrap into range.
   assign cfg_words = PROD_W'(i_feature_channel) * PROD_W'(i_feature_col) * KROW_P;
   assign cfg_bad   = (cfg_words == '0) || (i_band_total == '0) || (cfg_words > DEPTH_P);

   assign o_s_ready = (state_q == S_LOAD) && !i_reset_busy && i_enable;
   assign accept    = o_s_ready && i_s_valid;
   assign last_word = (BW_W'(addr_q) == (band_words_q - 1'b1));
   assign last_band = (band_idx_q == (band_total_q - 1'b1));

   always_comb begin
      // NOTE: every _d starts from its _q (or 0 for pulses) so no path leaves it unassigned and no latch is inferred.
      state_d      = state_q;
      addr_d       = addr_q;
      band_words_d = band_words_q;
      band_total_d = band_total_q;
      band_idx_d   = band_idx_q;
      cfg_error_d  = cfg_error_q;
      wenable_d    = 1'b0;
      waddress_d   = waddress_q;
      bram_data_d  = bram_data_q;
      start_d      = 1'b0;
      frame_done_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               cfg_error_d  = cfg_bad;
               band_words_d = cfg_words[BW_W-1:0];
               band_total_d = i_band_total;
               band_idx_d   = '0;
               addr_d       = '0;
               if (!cfg_bad) begin
                  state_d = S_WAIT_RST;
               end
            end
         end

         S_WAIT_RST: begin
            if (!i_reset_busy) begin
               state_d = S_LOAD;
            end
         end

         S_LOAD: begin
            if (accept) begin
               wenable_d   = 1'b1;
               waddress_d  = addr_q;
               bram_data_d = i_s_data;
               if (last_word) begin
                  addr_d  = '0;
                  state_d = S_START;
               end else begin
                  addr_d = addr_q + 1'b1;
               end
            end
         end

         // One cycle here guarantees the final write is already in memory when start is seen.
         S_START: begin
            start_d = 1'b1;
            state_d = S_HOLD;
         end

         S_HOLD: begin
            if (i_band_release) begin
               if (last_band) begin
                  frame_done_d = 1'b1;
                  band_idx_d   = '0;
                  state_d      = S_IDLE;
               end else begin
                  band_idx_d = band_idx_q + 1'b1;
                  state_d    = S_LOAD;
               end
            end
         end

         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         band_words_q <= '0;
         band_total_q <= '0;
         band_idx_q   <= '0;
         cfg_error_q  <= 1'b0;
         wenable_q    <= 1'b0;
         waddress_q   <= '0;
         bram_data_q  <= '0;
         start_q      <= 1'b0;
         frame_done_q <= 1'b0;
         busy_q       <= 1'b0;
      end else if (i_enable) begin
         // NOTE: non-blocking assignments so every register samples the pre-edge values.
         state_q      <= state_d;
         addr_q       <= addr_d;
         band_words_q <= band_words_d;
         band_total_q <= band_total_d;
         band_idx_q   <= band_idx_d;
         cfg_error_q  <= cfg_error_d;
         wenable_q    <= wenable_d;
         waddress_q   <= waddress_d;
         bram_data_q  <= bram_data_d;
         start_q      <= start_d;
         frame_done_q <= frame_done_d;
         busy_q       <= busy_d;
      end
   end

   assign o_wenable                = wenable_q;
   assign o_waddress               = waddress_q;
   assign o_bram_data              = bram_data_q;
   assign o_start_transfer_process = start_q;
   assign o_band_index             = band_idx_q;
   assign o_frame_done             = frame_done_q;
   assign o_cfg_error              = cfg_error_q;
   assign o_busy                   = busy_q;

endmodule

// File: tb/tb_input_bram_loader.sv
// Randomized bench for input_bram_loader: driver pushes expected writes into a queue,
// an independent monitor pops and compares every BRAM write and start pulse.
module tb_input_bram_loader;

   localparam int DEPTH = 1000;
   localparam int AW    = $clog2(DEPTH);
   localparam int DW    = 32;
   localparam int CW    = 8;
   localparam int COLW  = 6;
   localparam int BCW   = 6;

   logic            i_clock = 1'b0;
   logic            i_reset = 1'b0;
   logic            i_enable = 1'b1;
   logic            i_start = 1'b0;
   logic [CW-1:0]   i_feature_channel = '0;
   logic [COLW-1:0] i_feature_col = '0;
   logic [BCW-1:0]  i_band_total = '0;
   logic            i_s_valid = 1'b0;
   logic            o_s_ready;
   logic [DW-1:0]   i_s_data = '0;
   logic            i_reset_busy = 1'b0;
   logic            i_band_release = 1'b0;
   logic            o_wenable;
   logic [AW-1:0]   o_waddress;
   logic [DW-1:0]   o_bram_data;
   logic            o_start_transfer_process;
   logic [BCW-1:0]  o_band_index;
   logic            o_frame_done;
   logic            o_cfg_error;
   logic            o_busy;

   input_bram_loader #(
      .INPUT_BRAM_DEPTH   (DEPTH),
      .KERNEL_ROW_SIZE    (3),
      .DATA_WIDTH         (DW),
      .INPUT_CHANNEL_WIDTH(CW),
      .INPUT_COL_WIDTH    (COLW),
      .BAND_COUNT_WIDTH   (BCW)
   ) dut (
      .i_clock                 (i_clock),
      .i_reset                 (i_reset),
      .i_enable                (i_enable),
      .i_start                 (i_start),
      .i_feature_channel       (i_feature_channel),
      .i_feature_col           (i_feature_col),
      .i_band_total            (i_band_total),
      .i_s_valid               (i_s_valid),
      .o_s_ready               (o_s_ready),
      .i_s_data                (i_s_data),
      .i_reset_busy            (i_reset_busy),
      .i_band_release          (i_band_release),
      .o_wenable               (o_wenable),
      .o_waddress              (o_waddress),
      .o_bram_data             (o_bram_data),
      .o_start_transfer_process(o_start_transfer_process),
      .o_band_index            (o_band_index),
      .o_frame_done            (o_frame_done),
      .o_cfg_error             (o_cfg_error),
      .o_busy                  (o_busy)
   );

   always #5 i_clock = ~i_clock;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      bit            last;
      int            band;
   } wr_t;

   wr_t exp_q[$];
   int  checks = 0;
   int  errors = 0;
   int  starts_seen = 0;
   int  starts_exp = 0;
   bit  prev_last = 1'b0;
   int  last_band = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every write must match the next queued expectation; a start pulse must
   // follow the band's final write by exactly one cycle.
   always @(negedge i_clock) begin
      wr_t e;
      if (i_reset) begin
         if (o_start_transfer_process) begin
            starts_seen++;
            check("start_after_last_write", 64'(prev_last), 64'(1));
            check("start_band_index", 64'(o_band_index), 64'(last_band));
         end
         prev_last = 1'b0;
         if (o_wenable) begin
            if (exp_q.size() == 0) begin
               check("unexpected_write", 64'(o_wenable), 64'(0));
            end else begin
               e = exp_q.pop_front();
               check("write_addr", 64'(o_waddress), 64'(e.addr));
               check("write_data", 64'(o_bram_data), 64'(e.data));
               prev_last = e.last;
               last_band = e.band;
            end
         end
      end else begin
         prev_last = 1'b0;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic do_start(input int ch, input int col, input int bt);
      @(negedge i_clock);
      i_feature_channel = CW'(ch);
      i_feature_col     = COLW'(col);
      i_band_total      = BCW'(bt);
      i_start           = 1'b1;
      @(negedge i_clock);
      i_start = 1'b0;
   endtask

   // Present one word and hold it until the handshake completes; returns on a negedge.
   task automatic send_word(input int k, input bit last, input int band,
                            input bit bubbles, input bit seq_data);
      logic [DW-1:0] d;
      bit acc;
      d = seq_data ? DW'(k) : $urandom;
      exp_q.push_back('{AW'(k), d, last, band});
      if (bubbles && ($urandom_range(0, 1) == 1)) begin
         i_s_valid = 1'b0;
         @(negedge i_clock);
      end
      i_s_valid = 1'b1;
      i_s_data  = d;
      acc = 1'b0;
      for (int t = 0; t < 64 && !acc; t++) begin
         #1;
         acc = o_s_ready;
         @(negedge i_clock);
      end
      i_s_valid = 1'b0;
      if (!acc) check("accept_timeout", 64'(acc), 64'(1));
   endtask

   task automatic run_frame(input int ch, input int col, input int bt, input bit bubbles,
                            input bit busy_gap, input bit spurious, input bit seq_data);
      int  bw;
      bit  seen;
      bw = ch * col * 3;
      do_start(ch, col, bt);
      check("cfg_error_clear_on_start", 64'(o_cfg_error), 64'(0));
      check("busy_after_start", 64'(o_busy), 64'(1));
      for (int b = 0; b < bt; b++) begin
         for (int k = 0; k < bw; k++) begin
            if (busy_gap && b == 0 && k == 10) begin
               i_reset_busy = 1'b1;
               i_s_valid    = 1'b1;
               i_s_data     = 32'hdead_beef;
               for (int i = 0; i < 5; i++) begin
                  #1;
                  check("ready_low_while_rst_busy", 64'(o_s_ready), 64'(0));
                  if (i > 0) check("no_write_while_rst_busy", 64'(o_wenable), 64'(0));
                  @(negedge i_clock);
               end
               i_reset_busy = 1'b0;
               i_s_valid    = 1'b0;
            end
            if (spurious && k == 5) i_band_release = 1'b1;
            send_word(k, k == bw - 1, b, bubbles, seq_data);
            if (spurious && k == 5) begin
               i_band_release = 1'b0;
               check("band_index_after_load_release", 64'(o_band_index), 64'(b));
            end
         end
         starts_exp++;
         seen = 1'b0;
         for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge i_clock);
            seen = o_start_transfer_process;
         end
         check("start_pulse_seen", 64'(seen), 64'(1));
         for (int w = 0; w < 10; w++) begin
            @(negedge i_clock);
            if (w == 4) begin
               i_start           = 1'b0;
               i_feature_channel = CW'(ch);
               i_feature_col     = COLW'(col);
               i_band_total      = BCW'(bt);
            end
            if (spurious && w == 3) begin
               i_start           = 1'b1;
               i_feature_channel = 8'd7;
               i_feature_col     = 6'd7;
               i_band_total      = 6'd5;
            end
            #1;
            check("ready_low_in_hold", 64'(o_s_ready), 64'(0));
            check("band_index_in_hold", 64'(o_band_index), 64'(b));
            check("busy_in_hold", 64'(o_busy), 64'(1));
         end
         i_band_release = 1'b1;
         @(negedge i_clock);
         i_band_release = 1'b0;
         if (b == bt - 1) begin
            check("frame_done_pulse", 64'(o_frame_done), 64'(1));
            check("busy_after_frame", 64'(o_busy), 64'(0));
            check("band_index_cleared", 64'(o_band_index), 64'(0));
         end else begin
            check("no_early_frame_done", 64'(o_frame_done), 64'(0));
            check("band_index_advance", 64'(o_band_index), 64'(b + 1));
         end
      end
      @(negedge i_clock);
      check("frame_done_one_cycle", 64'(o_frame_done), 64'(0));
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_wenable"},  64'(o_wenable), 64'(0));
      check({tag, "_waddress"}, 64'(o_waddress), 64'(0));
      check({tag, "_data"},     64'(o_bram_data), 64'(0));
      check({tag, "_start"},    64'(o_start_transfer_process), 64'(0));
      check({tag, "_band_idx"}, 64'(o_band_index), 64'(0));
      check({tag, "_done"},     64'(o_frame_done), 64'(0));
      check({tag, "_cfg_err"},  64'(o_cfg_error), 64'(0));
      check({tag, "_busy"},     64'(o_busy), 64'(0));
      check({tag, "_ready"},    64'(o_s_ready), 64'(0));
   endtask

   task automatic bad_config(input int ch, input int col, input int bt);
      do_start(ch, col, bt);
      check("cfg_error_set", 64'(o_cfg_error), 64'(1));
      check("cfg_error_stays_idle", 64'(o_busy), 64'(0));
      i_s_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("cfg_error_no_ready", 64'(o_s_ready), 64'(0));
         @(negedge i_clock);
      end
      i_s_valid = 1'b0;
      check("cfg_error_sticky", 64'(o_cfg_error), 64'(1));
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge i_clock);
      check_outputs_zero("reset");
      i_reset = 1'b1;
      @(negedge i_clock);

      // Basic band, data equal to address
      run_frame(2, 4, 1, 1'b0, 1'b0, 1'b0, 1'b1);

      // Bubbles plus a reset-busy gap mid-band
      run_frame(2, 4, 1, 1'b1, 1'b1, 1'b0, 1'b0);

      // Multi-band frame
      run_frame(1, 3, 3, 1'b0, 1'b0, 1'b0, 1'b0);

      // Rejected configurations, then a valid restart
      bad_config(255, 63, 1);
      run_frame(1, 1, 1, 1'b0, 1'b0, 1'b0, 1'b0);
      bad_config(0, 5, 1);
      bad_config(3, 3, 0);
      bad_config(8, 42, 1);
      run_frame(9, 37, 1, 1'b1, 1'b0, 1'b0, 1'b0);

      // Reset in the middle of a band
      do_start(2, 4, 1);
      for (int k = 0; k < 10; k++) send_word(k, 1'b0, 0, 1'b0, 1'b0);
      #2;
      i_reset = 1'b0;
      #1;
      check_outputs_zero("mid_reset");
      check("mid_reset_queue_drained", 64'(exp_q.size()), 64'(0));
      repeat (3) @(negedge i_clock);
      i_reset = 1'b1;
      run_frame(2, 4, 1, 1'b1, 1'b0, 1'b0, 1'b0);

      // Spurious release in LOAD and spurious start in HOLD
      run_frame(2, 2, 2, 1'b0, 1'b0, 1'b1, 1'b0);

      repeat (3) @(negedge i_clock);
      check("all_writes_seen", 64'(exp_q.size()), 64'(0));
      check("start_pulse_count", 64'(starts_seen), 64'(starts_exp));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
